// File: rtl/pipe_stage_chain.sv
// Chain of STAGES valid/ready slices (pass or two-entry skid); a beat into an empty chain reaches out_valid STAGES cycles later.
// Stalls hold out_data stable; in skid mode in_ready comes from a flop, so there is no combinational ready path through the chain.
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SKID   = 0,
  parameter int CNT_W  = $clog2(STAGES*(SKID+1)+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  localparam int MAX_OCC = STAGES*(SKID+1);

  logic acc_in;
  logic acc_out;

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    logic             vi, ri, vo, ro;
    logic [WIDTH-1:0] di, dq;

    if (i == 0) begin : g_first
      assign vi = in_valid;
      assign di = in_data;
    end else begin : g_mid
      assign vi = g_slice[i-1].vo;
      assign di = g_slice[i-1].dq;
    end

    if (i == STAGES-1) begin : g_last
      assign ri = out_ready;
    end else begin : g_inner
      assign ri = g_slice[i+1].ro;
    end

    // Flush has priority inside every slice, so the raw handshakes need no gating here.
    if (SKID == 0) begin : g_pass
      logic             v;
      logic [WIDTH-1:0] d;

      assign ro = !v || ri;
      assign vo = v;
      assign dq = d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v <= 1'b0;
          d <= '0;
        end else if (flush) begin
          v <= 1'b0;
        end else if (vi && ro) begin
          v <= 1'b1;
          d <= di;
        end else if (ri && v) begin
          v <= 1'b0;
        end
      end
    end else begin : g_skid
      logic             m_v, s_v;
      logic [WIDTH-1:0] m_d, s_d;
      logic             acc, drain;

      assign ro    = !s_v;
      assign vo    = m_v;
      assign dq    = m_d;
      assign acc   = vi && !s_v;
      assign drain = m_v && ri;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m_v <= 1'b0;
          s_v <= 1'b0;
          m_d <= '0;
          s_d <= '0;
        end else if (flush) begin
          m_v <= 1'b0;
          s_v <= 1'b0;
        end else if (drain) begin
          // acc cannot coincide with s_v, so the skid entry never needs refilling here
          if (s_v) begin
            m_d <= s_d;
            s_v <= 1'b0;
          end else if (acc) begin
            m_d <= di;
          end else begin
            m_v <= 1'b0;
          end
        end else if (acc) begin
          if (!m_v) begin
            m_v <= 1'b1;
            m_d <= di;
          end else begin
            s_v <= 1'b1;
            s_d <= di;
          end
        end
      end
    end
  end

  assign in_ready  = g_slice[0].ro && !flush;
  assign out_valid = g_slice[STAGES-1].vo && !flush;
  assign out_data  = g_slice[STAGES-1].dq;
  assign acc_in    = in_valid && in_ready;
  assign acc_out   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (acc_in && !acc_out) begin
      occupancy <= occupancy + CNT_W'(1);
    end else if (!acc_in && acc_out) begin
      occupancy <= occupancy - CNT_W'(1);
    end
  end

`ifdef ASSERTIONS
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> flush || (out_valid && $stable(out_data)));
  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= CNT_W'(MAX_OCC));
  if (SKID != 0) begin : g_skid_chk
    a_rdy_flop: assert property (@(posedge clk) disable iff (!rst_n)
      in_ready == (!g_slice[0].g_skid.s_v && !flush));
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Three chain configurations (3-stage pass, 2-stage skid, 1-stage pass) driven by directed vectors;
// a negedge monitor pops expected beats from per-instance queues and tracks occupancy.
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush     [3];
  logic [31:0] in_data   [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] out_data  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [1:0]  occ_a;
  logic [2:0]  occ_b;
  logic [0:0]  occ_c;

  int checks = 0;
  int errors = 0;
  int cnt [3];
  bit stall_prev [3];
  logic [31:0] data_prev [3];
  logic [31:0] q0[$], q1[$], q2[$];

  logic [31:0] exp_od  [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
  bit          exp_ir  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  int          exp_occ [7] = '{4, 3, 2, 2, 2, 1, 0};

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(32), .STAGES(3), .SKID(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .occupancy(occ_a));

  pipe_stage_chain #(.WIDTH(32), .STAGES(2), .SKID(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .occupancy(occ_b));

  pipe_stage_chain #(.WIDTH(32), .STAGES(1), .SKID(0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush[2]),
    .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .occupancy(occ_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic int occ_of(input int k);
    case (k)
      0:       return int'(occ_a);
      1:       return int'(occ_b);
      default: return int'(occ_c);
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] q_pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic q_push(input int k, input logic [31:0] d);
    case (k)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic q_clear(input int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic mon_step(input int k);
    logic [31:0] d;
    bit ai, ao;
    if (!rst_n) begin
      q_clear(k);
      cnt[k] = 0;
      stall_prev[k] = 1'b0;
    end else begin
      chk($sformatf("occ[%0d]", k), occ_of(k), cnt[k]);
      if (stall_prev[k] && !flush[k]) begin
        chk1($sformatf("hold_valid[%0d]", k), out_valid[k], 1'b1);
        chk($sformatf("hold_data[%0d]", k), out_data[k], data_prev[k]);
      end
      ai = in_valid[k] && in_ready[k];
      ao = out_valid[k] && out_ready[k];
      if (ao) begin
        if (qsize(k) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat[%0d]: got 0x%0h expected none", k, out_data[k]);
        end else begin
          d = q_pop(k);
          chk($sformatf("order[%0d]", k), out_data[k], d);
        end
      end
      if (ai) q_push(k, in_data[k]);
      cnt[k] += int'(ai) - int'(ao);
      if (flush[k]) begin
        q_clear(k);
        cnt[k] = 0;
      end
      stall_prev[k] = out_valid[k] && !out_ready[k];
      data_prev[k]  = out_data[k];
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) mon_step(k);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int k);
    int t = 0;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    while ((qsize(k) != 0 || out_valid[k]) && t < 200) begin
      cyc();
      t++;
    end
    chk($sformatf("drain_q[%0d]", k), qsize(k), 0);
    chk($sformatf("drain_occ[%0d]", k), occ_of(k), 0);
  endtask

  task automatic rand_run(input int k, input int n);
    int sent = 0;
    int guard = 0;
    bit acc = 1'b0;
    in_valid[k] = 1'b0;
    while (sent < n && guard < 20000) begin
      if (!in_valid[k] || acc) begin
        in_valid[k] = ($urandom_range(0, 1) == 1);
        in_data[k]  = $urandom;
      end
      out_ready[k] = ($urandom_range(0, 1) == 1);
      #1;
      acc = in_valid[k] && in_ready[k];
      if (acc) sent++;
      @(posedge clk);
      #1;
      guard++;
    end
    chk($sformatf("rand_sent[%0d]", k), sent, n);
    drain(k);
  endtask

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      flush[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b1;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("rst_out_valid[%0d]", k), out_valid[k], 1'b0);
      chk($sformatf("rst_out_data[%0d]", k), out_data[k], 32'h0);
      chk($sformatf("rst_occ[%0d]", k), occ_of(k), 0);
      chk1($sformatf("rst_in_ready[%0d]", k), in_ready[k], 1'b1);
    end
    cyc();
    rst_n = 1'b1;
    cyc();

    // Stream: 3-stage pass chain, 0x1..0x8 back to back
    for (int c = 0; c < 12; c++) begin
      in_valid[0] = (c < 8);
      in_data[0]  = (c < 8) ? 32'(c + 1) : 32'h0;
      #1;
      if (c < 8) chk1("stream_in_ready", in_ready[0], 1'b1);
      chk1("stream_out_valid", out_valid[0], (c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) chk("stream_out_data", out_data[0], 32'(c - 2));
      if (c >= 3 && c <= 8) chk("stream_occ", occ_of(0), 3);
      cyc();
    end
    drain(0);

    // Fill and stall: 2-stage skid chain holds 4 beats, then drains in order
    out_ready[1] = 1'b0;
    for (int c = 0; c < 14; c++) begin
      out_ready[1] = (c >= 7);
      if (c < 4) begin
        in_valid[1] = 1'b1; in_data[1] = 32'hA0 + 32'(c);
      end else if (c < 10) begin
        in_valid[1] = 1'b1; in_data[1] = 32'hA4;
      end else if (c == 10) begin
        in_valid[1] = 1'b1; in_data[1] = 32'hA5;
      end else begin
        in_valid[1] = 1'b0;
      end
      #1;
      if (c < 4) begin
        chk1("fill_in_ready", in_ready[1], 1'b1);
      end else if (c < 7) begin
        chk1("full_in_ready", in_ready[1], 1'b0);
        chk("full_occ", occ_of(1), 4);
        chk1("full_out_valid", out_valid[1], 1'b1);
        chk("full_out_data", out_data[1], 32'hA0);
      end else begin
        chk1("drain_in_ready", in_ready[1], exp_ir[c-7]);
        chk("drain_occ_seq", occ_of(1), exp_occ[c-7]);
        chk1("drain_out_valid", out_valid[1], (c < 13));
        if (c < 13) chk("drain_out_data", out_data[1], exp_od[c-7]);
      end
      cyc();
    end
    drain(1);

    // Single pass stage: stalled beat 0x7 blocks input, then swaps with 0x8 in one cycle
    out_ready[2] = 1'b0;
    in_valid[2] = 1'b1; in_data[2] = 32'h7;
    #1;
    chk1("one_first_ready", in_ready[2], 1'b1);
    cyc();
    for (int c = 0; c < 2; c++) begin
      in_valid[2] = 1'b1; in_data[2] = 32'h8;
      #1;
      chk1("one_stall_ready", in_ready[2], 1'b0);
      chk1("one_stall_valid", out_valid[2], 1'b1);
      chk("one_stall_data", out_data[2], 32'h7);
      chk("one_stall_occ", occ_of(2), 1);
      cyc();
    end
    out_ready[2] = 1'b1;
    #1;
    chk1("one_swap_ready", in_ready[2], 1'b1);
    chk("one_swap_data", out_data[2], 32'h7);
    cyc();
    out_ready[2] = 1'b0; in_valid[2] = 1'b0;
    #1;
    chk1("one_next_valid", out_valid[2], 1'b1);
    chk("one_next_data", out_data[2], 32'h8);
    chk("one_next_occ", occ_of(2), 1);
    cyc();
    drain(2);

    // Random backpressure on both modes at once
    fork
      rand_run(0, 1000);
      rand_run(1, 1000);
    join

    // Flush on the skid chain with three beats held
    out_ready[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid[1] = 1'b1; in_data[1] = 32'hB0 + 32'(c);
      #1;
      chk1("pre_flush_ready", in_ready[1], 1'b1);
      cyc();
    end
    flush[1] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 32'h99; out_ready[1] = 1'b1;
    #1;
    chk("pre_flush_occ", occ_of(1), 3);
    chk1("flush_in_ready", in_ready[1], 1'b0);
    chk1("flush_out_valid", out_valid[1], 1'b0);
    cyc();
    flush[1] = 1'b0; in_valid[1] = 1'b1; in_data[1] = 32'h55;
    #1;
    chk("post_flush_occ", occ_of(1), 0);
    chk1("post_flush_valid", out_valid[1], 1'b0);
    chk1("post_flush_ready", in_ready[1], 1'b1);
    cyc();
    in_valid[1] = 1'b0;
    #1;
    chk1("flush_lat_early", out_valid[1], 1'b0);
    cyc();
    chk1("flush_lat_valid", out_valid[1], 1'b1);
    chk("flush_lat_data", out_data[1], 32'h55);
    drain(1);

    // Asynchronous reset between edges while the pass chain streams
    out_ready[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid[0] = 1'b1; in_data[0] = 32'h30 + 32'(c);
      #1;
      if (c == 3) begin
        chk1("pre_rst_valid", out_valid[0], 1'b1);
        chk("pre_rst_data", out_data[0], 32'h30);
      end
      cyc();
    end
    in_data[0] = 32'h34;
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_out_valid", out_valid[0], 1'b0);
    chk("arst_out_data", out_data[0], 32'h0);
    chk("arst_occ", occ_of(0), 0);
    chk1("arst_in_ready", in_ready[0], 1'b1);
    chk("arst_skid_data", out_data[1], 32'h0);
    chk("arst_one_data", out_data[2], 32'h0);
    in_valid[0] = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = (c < 3);
      in_data[0]  = 32'h11 + 32'(c);
      #1;
      if (c == 3) begin
        chk1("post_rst_valid", out_valid[0], 1'b1);
        chk("post_rst_data", out_data[0], 32'h11);
      end
      cyc();
    end
    drain(0);

    for (int k = 0; k < 3; k++) chk($sformatf("final_q[%0d]", k), qsize(k), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of STAGES valid/ready register slices between an upstream producer and a downstream consumer.
- Generalises the single-entry pipeline register in three ways:
  - configurable depth and data width;
  - a selectable slice mode: a simple pass slice, or a two-entry skid slice whose ready is driven only by flops;
  - a synchronous flush input and an occupancy count.
- Used to retime long valid/ready paths and to break combinational ready chains.

Parameters:
- WIDTH, 32, data bits per beat.
- STAGES, 2, number of slices in the chain (at least 1).
- SKID, 0: 0 selects pass slices, 1 selects skid slices (all slices use the same mode).
- CNT_W, $clog2(STAGES*(SKID+1)+1), width of the occupancy output (derived; do not override).

Ports:
- clk  input  1  clock, all state on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- flush  input  1  synchronous discard of all held beats.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  chain accepts the beat this cycle.
- out_data  output  WIDTH  downstream data (head of chain).
- out_valid  output  1  head beat present.
- out_ready  input  1  downstream accepts the head beat.
- occupancy  output  CNT_W  number of valid beats held across all slices.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: all valid flags 0 and all data registers 0. Outputs: out_valid=0, out_data=0, occupancy=0. in_ready=1 in both modes.
- Transfer rule: a beat moves on a boundary when valid and ready are both 1 in the same cycle. Ordering is strictly FIFO, with no duplication and no loss.
- Slice i has input side (v_in, r_out) and output side (v_out, r_in). Slice 0 connects to in_*. Slice STAGES-1 connects to out_*.
- Pass slice (SKID=0):
  - one entry {v, d}; r_out = !v || r_in (combinational through the chain);
  - on accept: d <= input data, v <= 1;
  - else if r_in && v: v <= 0;
  - capacity 1; full throughput of 1 beat/cycle.
- Skid slice (SKID=1):
  - two entries, main M and skid S; r_out = !S.v, a pure flop output;
  - output side presents M.
  - If M drains (M.v && r_in): M <= S when S.v, else M <= the accepted input, else M.v <= 0. When S.v, S clears.
  - If M does not drain and a beat is accepted: the beat goes to M when !M.v, else to S.
  - Capacity 2; full throughput; no combinational path from out_ready to in_ready.
- Latency:
  - an accepted beat with an empty chain and out_ready=1 appears on out_valid exactly STAGES cycles after acceptance (both modes);
  - there is no same-cycle pass-through.
- Backpressure: while out_valid=1 and out_ready=0, out_valid and out_data hold stable until accepted.
- Flush:
  - sampled at the clock edge; has priority over all transfers;
  - in the flush cycle, in_ready=0 and out_valid=0 are forced combinationally, so no transfer occurs on either boundary;
  - at the next edge all valid flags clear and occupancy becomes 0;
  - data registers are left unchanged.
- Occupancy:
  - registered sum of all valid flags, updated each edge as +1 on input acceptance and -1 on output acceptance; both in the same cycle gives no change;
  - maximum value STAGES*(SKID+1); never wraps.
- Full chain:
  - pass mode: in_ready=1 only when out_ready ripples through (a full chain still streams if out_ready=1);
  - skid mode: in_ready=0 when slice 0 S.v=1.
- Empty chain: out_valid=0; out_data holds its last value, which is don't-care.
- Reset mid-operation: all beats are discarded immediately (asynchronous); state is identical to post-reset.
- Assertions (ASSERTIONS define):
  - out_valid && !out_ready |=> out_valid && $stable(out_data);
  - occupancy <= STAGES*(SKID+1);
  - SKID=1: in_ready has no dependency on out_ready in the same cycle.

Test Plan:
- Stream: STAGES=3, SKID=0, out_ready=1, send 0x1..0x8 back-to-back -> out_data 0x1..0x8 in order, first out_valid 3 cycles after the first accept, 1 beat/cycle, occupancy steady at 3.
- Fill and stall: STAGES=2, SKID=1, out_ready=0, send 0xA0..0xA5 -> 4 beats accepted, in_ready=0 after the 4th, occupancy=4. Raise out_ready -> 0xA0..0xA3 then 0xA4, 0xA5 emerge, no loss or duplication.
- Random backpressure: both modes, 1000 beats with 50% random in_valid/out_ready -> scoreboard matches in order, out_data stable under stall, occupancy tracks the scoreboard count.
- Flush: SKID=1, occupancy=3, assert flush one cycle with in_valid=1 and out_ready=1 -> no transfer that cycle, occupancy=0 and out_valid=0 next cycle, the next beat 0x55 exits after STAGES cycles.
- Async reset: drop rst_n mid-stream between clock edges -> out_valid=0, out_data=0, occupancy=0 immediately, in_ready=1. After release, fresh traffic passes correctly.
- Edge case: STAGES=1, SKID=0, out_ready held 0 after one beat 0x7 -> in_ready=0 and out_data=0x7 held. Pulse out_ready with in_valid=1 -> 0x7 delivered and the new beat accepted in the same cycle.
